// File: rtl/mem_loader.sv
// Streams 2^AW bytes over valid/ready into consecutive memory locations from address 0.
// Optional running checksum output is enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    localparam logic [AW:0] CountOne = (AW + 1)'(1);

    state_e state;
    logic   xfer;

    // Abort blocks acceptance in the same cycle so no byte is taken on the way out.
    assign din_ready = (state == StLoad) && !abort;
    assign xfer      = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StLoad;
                        busy  <= 1'b1;
                        count <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                StLoad: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        we    <= 1'b1;
                        waddr <= count[AW-1:0];
                        wdata <= din;
                        count <= count + CountOne;
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum  <= csum + din;
`endif
                        // count never reaches 2^AW inside LOAD, so all-ones low bits marks the last byte
                        if (&count[AW-1:0]) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed scenarios with random data and gaps,
// checked against a write log compared to the bytes the bench offered.
module tb_mem_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] stim [DEPTH];

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int cyc      = 0;

    mem_loader #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .count    (count)
`ifdef MEM_LOADER_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log: what the memory would capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr_q.push_back(int'(waddr));
            wr_data_q.push_back(int'(wdata));
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_after_start", {31'd0, din_ready}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("count_cleared", {27'd0, count}, 32'd0);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic feed(input int n, input int mode, input int start_at);
        int idx = 0;
        int c   = 0;
        bit v;
        while (idx < n && c < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            din_valid = v;
            din       = v ? stim[idx] : 8'($urandom);
            start     = (c == start_at);
            tick();
            if (v) idx++;
            c++;
        end
        din_valid = 1'b0;
        start     = 1'b0;
        if (idx < n) chk("feed_budget", idx, n);
    endtask

    task automatic check_log(input string tag, input int mark, input int n);
        chk({tag, "_nwrites"}, wr_addr_q.size() - mark, n);
        for (int i = 0; i < n && mark + i < wr_addr_q.size(); i++) begin
            chk({tag, "_waddr"}, wr_addr_q[mark+i], i);
            chk({tag, "_wdata"}, wr_data_q[mark+i], int'(stim[i]));
        end
    endtask

    task automatic check_span(input string tag, input int mark, input int span);
        if (wr_cyc_q.size() > mark) begin
            chk({tag, "_span"}, wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[mark], span);
            chk({tag, "_done_with_last_we"}, done_cyc, wr_cyc_q[wr_cyc_q.size()-1]);
        end else begin
            chk({tag, "_no_writes_seen"}, 0, 1);
        end
    endtask

`ifdef MEM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(stim[i]);
        return 8'(s % 256);
    endfunction
`endif

    task automatic check_done_cycle(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        chk({tag, "_we_last"}, {31'd0, we}, 32'd1);
        chk({tag, "_waddr_last"}, {28'd0, waddr}, 32'd15);
        chk({tag, "_count_full"}, {27'd0, count}, 32'd16);
        chk({tag, "_ready_done"}, {31'd0, din_ready}, 32'd0);
        tick();
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_we_after"}, {31'd0, we}, 32'd0);
    endtask

    initial begin
        int mark;
        int dmark;

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) tick();
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, din_ready}, 32'd0);
        chk("rst_waddr", {28'd0, waddr}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("rst_csum", {24'd0, csum}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Full back-to-back load of 0x10..0x1F
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'(16 + i);
        mark  = wr_addr_q.size();
        dmark = done_cnt;
        start_load();
        feed(16, 0, -1);
        check_done_cycle("full");
        check_log("full", mark, 16);
        check_span("full", mark, 15);
        chk("full_done_once", done_cnt - dmark, 1);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("full_csum", {24'd0, csum}, {24'd0, model_sum(16)});
`endif

        // Same data, valid every other cycle
        mark  = wr_addr_q.size();
        dmark = done_cnt;
        start_load();
        feed(16, 1, -1);
        check_done_cycle("stall");
        check_log("stall", mark, 16);
        check_span("stall", mark, 30);
        chk("stall_done_once", done_cnt - dmark, 1);

        // Abort after 5 random bytes while valid stays high
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
        mark  = wr_addr_q.size();
        dmark = done_cnt;
        start_load();
        feed(5, 0, -1);
        abort     = 1'b1;
        din_valid = 1'b1;
        din       = stim[5];
        #1;
        chk("abort_ready", {31'd0, din_ready}, 32'd0);
        chk("abort_prev_we", {31'd0, we}, 32'd1);
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_we", {31'd0, we}, 32'd0);
        chk("abort_count", {27'd0, count}, 32'd5);
        repeat (3) tick();
        chk("abort_idle_ready", {31'd0, din_ready}, 32'd0);
        din_valid = 1'b0;
        chk("abort_count_hold", {27'd0, count}, 32'd5);
        check_log("abort", mark, 5);
        chk("abort_no_done", done_cnt - dmark, 0);

        // Restart with random data, random gaps and a stray start mid-load
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
        mark  = wr_addr_q.size();
        dmark = done_cnt;
        start_load();
        feed(16, 2, 3);
        check_done_cycle("rand");
        check_log("rand", mark, 16);
        chk("rand_done_once", done_cnt - dmark, 1);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("rand_csum", {24'd0, csum}, {24'd0, model_sum(16)});
`endif

        // Valid data and abort while idle are ignored
        mark      = wr_addr_q.size();
        din       = 8'hAA;
        din_valid = 1'b1;
        abort     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready", {31'd0, din_ready}, 32'd0);
        end
        din_valid = 1'b0;
        abort     = 1'b0;
        chk("idle_no_we", wr_addr_q.size() - mark, 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_count", {27'd0, count}, 32'd16);

        // Reset after 7 bytes with valid held high
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
        mark  = wr_addr_q.size();
        dmark = done_cnt;
        start_load();
        feed(7, 0, -1);
        din_valid = 1'b1;
        din       = stim[7];
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_we", {31'd0, we}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_ready", {31'd0, din_ready}, 32'd0);
        chk("mrst_waddr", {28'd0, waddr}, 32'd0);
        chk("mrst_wdata", {24'd0, wdata}, 32'd0);
        chk("mrst_count", {27'd0, count}, 32'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
        chk("mrst_csum", {24'd0, csum}, 32'd0);
`endif
        repeat (4) tick();
        din_valid = 1'b0;
        tick();
        check_log("mrst", mark, 7);
        chk("mrst_no_done", done_cnt - dmark, 0);
        chk("mrst_idle_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
